bram_wr_port: RTL and testbench

//  Write-side companion to the BRAM read port: accepts a burst command (base address, length)
//  and a valid/ready data stream, and writes the words to sequential addresses on a

---
 rtl/bram_wr_port.sv | 115 +++++++++++
 tb/tb_bram_wr_port.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bram_wr_port.sv
// Burst write port: takes a (base, len) command and a valid/ready data stream and
// writes the words to sequential BRAM addresses, pulsing done when the burst ends.
module bram_wr_port #(
    parameter int unsigned W_DATA = 8,
    parameter int unsigned W_ADDR = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [W_ADDR-1:0] cmd_base,
    input  logic [W_ADDR:0]   cmd_len,
    input  logic              data1_valid,
    output logic              data1_ready,
    input  logic [W_DATA-1:0] data1,
    output logic              ena,
    output logic              wea,
    output logic [W_ADDR-1:0] addra,
    output logic [W_DATA-1:0] dia,
    output logic              busy,
    output logic              done,
    output logic [W_ADDR:0]   wr_count
);

    localparam int unsigned W_CNT = W_ADDR + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [W_ADDR-1:0] addr_reg;
    logic [W_CNT-1:0]  remaining;
    logic              cmd_acc_c;
    logic              beat_acc_c;

    assign cmd_acc_c  = cmd_valid & cmd_ready;
    assign beat_acc_c = data1_valid & data1_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_acc_c) begin
                    state_nxt = (cmd_len != W_CNT'(0)) ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (beat_acc_c && (remaining == W_CNT'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status decoded from the state register only
    always_comb begin
        cmd_ready   = 1'b0;
        data1_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = ~rst;
                busy      = 1'b0;
            end
            WRITE:   data1_ready = 1'b1;
            DONE:    done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Address/count tracking and registered BRAM strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg  <= '0;
            remaining <= '0;
            wr_count  <= '0;
            ena       <= 1'b0;
            addra     <= '0;
            dia       <= '0;
        end else begin
            ena <= beat_acc_c;
            if (cmd_acc_c) begin
                addr_reg  <= cmd_base;
                remaining <= cmd_len;
                wr_count  <= '0;
            end else if (beat_acc_c) begin
                addra     <= addr_reg;
                dia       <= data1;
                addr_reg  <= addr_reg + W_ADDR'(1);
                remaining <= remaining - W_CNT'(1);
                wr_count  <= wr_count + W_CNT'(1);
            end
        end
    end

    assign wea = ena;

endmodule

// File: tb/tb_bram_wr_port.sv
// Self-checking bench for bram_wr_port: expected BRAM writes are queued as beats are
// accepted and compared as the write strobes appear.
module tb_bram_wr_port;

    localparam int unsigned W_DATA = 8;
    localparam int unsigned W_ADDR = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [W_ADDR-1:0] cmd_base = '0;
    logic [W_ADDR:0]   cmd_len = '0;
    logic              data1_valid = 1'b0;
    logic              data1_ready;
    logic [W_DATA-1:0] data1 = '0;
    logic              ena;
    logic              wea;
    logic [W_ADDR-1:0] addra;
    logic [W_DATA-1:0] dia;
    logic              busy;
    logic              done;
    logic [W_ADDR:0]   wr_count;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic [W_ADDR+W_DATA-1:0] sb[$];

    bram_wr_port #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .data1_valid(data1_valid), .data1_ready(data1_ready), .data1(data1),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .busy(busy), .done(done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            logic [W_ADDR+W_DATA-1:0] e;
            if (done) done_seen++;
            chk("wea_eq_ena", 32'(wea), 32'(ena));
            if (ena) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'(addra), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("addra", 32'(addra), 32'(e[W_ADDR+W_DATA-1:W_DATA]));
                    chk("dia", 32'(dia), 32'(e[W_DATA-1:0]));
                end
            end
        end
    end

    // Returns at accept edge + 1ns
    task automatic send_cmd(input logic [W_ADDR-1:0] base, input logic [W_ADDR:0] len);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_timeout", 32'(n < 50), 32'd1);
        cmd_base  = base;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Called at edge + 1ns; returns at accept edge + 1ns
    task automatic send_beat(input logic [W_DATA-1:0] d, input logic [W_ADDR-1:0] a);
        int n = 0;
        data1       = d;
        data1_valid = 1'b1;
        while (!data1_ready && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("data_ready_timeout", 32'(n < 50), 32'd1);
        sb.push_back({a, d});
        @(posedge clk);
        #1 data1_valid = 1'b0;
    endtask

    task automatic run_burst(input logic [W_ADDR-1:0] base, input logic [W_ADDR:0] len,
                             input logic [W_DATA-1:0] dbase, input int gap);
        logic [W_ADDR-1:0] a;
        send_cmd(base, len);
        chk("busy_after_cmd", 32'(busy), 32'd1);
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        if (len == 0) begin
            chk("len0_done", 32'(done), 32'd1);
            chk("len0_no_ena", 32'(ena), 32'd0);
        end else begin
            chk("wr_count_start", 32'(wr_count), 32'd0);
            for (int i = 0; i < int'(len); i++) begin
                if (i > 0) repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                a = base + W_ADDR'(i);
                send_beat(dbase + W_DATA'(i), a);
            end
            chk("done_with_last", 32'(done), 32'd1);
            chk("ena_with_last", 32'(ena), 32'd1);
            chk("wr_count_final", 32'(wr_count), 32'(len));
        end
        @(posedge clk);
        #1;
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("done_single", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("wr_count_hold", 32'(wr_count), 32'(len));
    endtask

    initial begin
        // Reset asserted from time zero, released mid-cycle
        #12;
        chk("rst_ena", 32'(ena), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("cmd_ready_release", 32'(cmd_ready), 32'd1);

        run_burst(12'h010, 13'd4, 8'hA0, 0);
        run_burst(12'h010, 13'd4, 8'hB0, 2);
        run_burst(12'hFFE, 13'd4, 8'hC0, 0);
        run_burst(12'h055, 13'd0, 8'h00, 0);
        run_burst(12'h020, 13'd1, 8'hD0, 0);

        // Reset after two beats of a five-beat burst
        send_cmd(12'h200, 13'd5);
        send_beat(8'hE0, 12'h200);
        send_beat(8'hE1, 12'h201);
        chk("pre_rst_ena", 32'(ena), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ena", 32'(ena), 32'd0);
        chk("mid_rst_wea", 32'(wea), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_wr_count", 32'(wr_count), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        chk("sb_empty_rst", 32'(sb.size()), 32'd0);
        run_burst(12'h100, 13'd2, 8'hF0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 32'(done_seen), 32'd6);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
